result_write_arbiter: RTL and testbench

Downstream merge stage between the parallel box-filter lanes and the single pixel-write port of the output frame memory. Each lane's sparse result writes are buffered in a small per-lane FIFO. A round-robin arbiter drains the FIFOs onto one registered write port, one pixel per cycle. Simultaneous lane writes are therefore serialized without loss, replacing the "last wren wins" output mux.

---
 rtl/adaptive_threshold_pkg.sv | 14 +
 rtl/result_lane_fifo.sv | 62 ++++++
 rtl/result_write_arbiter.sv | 150 +++++++++++++++
 tb/tb_result_write_arbiter.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/adaptive_threshold_pkg.sv
// Shared constants and the lane result entry type for the adaptive threshold output path.
package adaptive_threshold_pkg;

   localparam int unsigned NUM_LANES_BITS = 2;
   localparam int unsigned WIDTH_BITS     = 8;
   localparam int unsigned HEIGHT_BITS    = 8;

   typedef struct packed {
      logic [HEIGHT_BITS-1:0] row;
      logic [WIDTH_BITS-1:0]  col;
      logic                   data;
   } result_entry_t;

endpackage

// File: rtl/result_lane_fifo.sv
// Single-lane result FIFO; a push into a full FIFO is accepted only when the head pops in the same cycle.
module result_lane_fifo
   import adaptive_threshold_pkg::*;
#(
   parameter int unsigned DEPTH_BITS = 2
) (
   input  logic                  not_reset,
   input  logic                  clock,
   input  logic                  push_i,
   input  logic                  pop_i,
   input  result_entry_t         entry_i,
   output result_entry_t         head_o,
   output logic [DEPTH_BITS:0]   count_o,
   output logic                  full_o
);

   localparam int unsigned DEPTH = 1 << DEPTH_BITS;
   localparam int unsigned CW    = DEPTH_BITS + 1;

   result_entry_t         mem_q [DEPTH];
   logic [DEPTH_BITS-1:0] wr_ptr_q, wr_ptr_d;
   logic [DEPTH_BITS-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]         count_q, count_d;
   logic                  push_ok_c, pop_ok_c;

   assign full_o  = (count_q == CW'(DEPTH));
   assign count_o = count_q;
   assign head_o  = mem_q[rd_ptr_q];

   always_comb begin
      wr_ptr_d  = wr_ptr_q;
      rd_ptr_d  = rd_ptr_q;
      count_d   = count_q;
      pop_ok_c  = pop_i && (count_q != '0);
      push_ok_c = push_i && (!full_o || pop_ok_c);
      if (push_ok_c) wr_ptr_d = wr_ptr_q + DEPTH_BITS'(1);
      if (pop_ok_c)  rd_ptr_d = rd_ptr_q + DEPTH_BITS'(1);
      case ({push_ok_c, pop_ok_c})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clock or negedge not_reset) begin
      if (!not_reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage needs no reset: the count gates every read.
   always_ff @(posedge clock) begin
      if (push_ok_c) mem_q[wr_ptr_q] <= entry_i;
   end

endmodule

// File: rtl/result_write_arbiter.sv
// Per-lane result FIFOs drained round-robin onto one registered pixel-write port.
// RESULT_ARB_STATS_EN adds the sticky per-lane overflow flags and a saturating drop counter.
module result_write_arbiter #(
   parameter int unsigned NUM_LANES_BITS  = adaptive_threshold_pkg::NUM_LANES_BITS,
   parameter int unsigned NUM_LANES       = 1 << NUM_LANES_BITS,
   parameter int unsigned WIDTH_BITS      = adaptive_threshold_pkg::WIDTH_BITS,
   parameter int unsigned HEIGHT_BITS     = adaptive_threshold_pkg::HEIGHT_BITS,
   parameter int unsigned FIFO_DEPTH_BITS = 2
) (
   input  logic                              not_reset,
   input  logic                              clock,
   input  logic [NUM_LANES*WIDTH_BITS-1:0]   iCol,
   input  logic [NUM_LANES*HEIGHT_BITS-1:0]  iRow,
   input  logic [NUM_LANES-1:0]              iData,
   input  logic [NUM_LANES-1:0]              iWren,
   output logic [NUM_LANES-1:0]              oFull,
   output logic [HEIGHT_BITS-1:0]            oX,
   output logic [WIDTH_BITS-1:0]             oY,
   output logic [2:0]                        oR,
   output logic [2:0]                        oG,
   output logic [2:0]                        oB,
   output logic                              oWren,
   output logic                              oIdle
`ifdef RESULT_ARB_STATS_EN
   ,
   output logic [NUM_LANES-1:0]              oOverflow,
   output logic [15:0]                       oDropCount
`endif
);

   adaptive_threshold_pkg::result_entry_t entry_c [NUM_LANES];
   adaptive_threshold_pkg::result_entry_t head_c  [NUM_LANES];
   logic [FIFO_DEPTH_BITS:0]  count_c [NUM_LANES];
   logic [NUM_LANES-1:0]      full_c, nonempty_c, pop_c;

   logic                      grant_valid_c;
   logic [NUM_LANES_BITS-1:0] grant_idx_c, cand_c;

   logic [NUM_LANES_BITS-1:0] last_grant_q, last_grant_d;
   logic [HEIGHT_BITS-1:0]    x_q, x_d;
   logic [WIDTH_BITS-1:0]     y_q, y_d;
   logic                      pix_q, pix_d;
   logic                      wren_q, wren_d;

   for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
      assign entry_c[i]    = {iRow[i*HEIGHT_BITS +: HEIGHT_BITS], iCol[i*WIDTH_BITS +: WIDTH_BITS], iData[i]};
      assign nonempty_c[i] = (count_c[i] != '0);
      assign pop_c[i]      = grant_valid_c && (grant_idx_c == NUM_LANES_BITS'(i));

      result_lane_fifo #(
         .DEPTH_BITS (FIFO_DEPTH_BITS)
      ) u_fifo (
         .not_reset (not_reset),
         .clock     (clock),
         .push_i    (iWren[i]),
         .pop_i     (pop_c[i]),
         .entry_i   (entry_c[i]),
         .head_o    (head_c[i]),
         .count_o   (count_c[i]),
         .full_o    (full_c[i])
      );
   end

   // Round-robin search starting one past the last granted lane.
   always_comb begin
      grant_valid_c = 1'b0;
      grant_idx_c   = '0;
      cand_c        = '0;
      for (int k = 1; k <= int'(NUM_LANES); k++) begin
         cand_c = last_grant_q + NUM_LANES_BITS'(k);
         if (!grant_valid_c && nonempty_c[cand_c]) begin
            grant_valid_c = 1'b1;
            grant_idx_c   = cand_c;
         end
      end
   end

   always_comb begin
      last_grant_d = last_grant_q;
      x_d          = x_q;
      y_d          = y_q;
      pix_d        = pix_q;
      wren_d       = 1'b0;
      if (grant_valid_c) begin
         last_grant_d = grant_idx_c;
         x_d          = head_c[grant_idx_c].row;
         y_d          = head_c[grant_idx_c].col;
         pix_d        = head_c[grant_idx_c].data;
         wren_d       = 1'b1;
      end
   end

   always_ff @(posedge clock or negedge not_reset) begin
      if (!not_reset) begin
         last_grant_q <= NUM_LANES_BITS'(NUM_LANES - 1);
         x_q          <= '0;
         y_q          <= '0;
         pix_q        <= 1'b0;
         wren_q       <= 1'b0;
      end else begin
         last_grant_q <= last_grant_d;
         x_q          <= x_d;
         y_q          <= y_d;
         pix_q        <= pix_d;
         wren_q       <= wren_d;
      end
   end

   assign oFull = full_c;
   assign oX    = x_q;
   assign oY    = y_q;
   assign oR    = {3{pix_q}};
   assign oG    = {3{pix_q}};
   assign oB    = {3{pix_q}};
   assign oWren = wren_q;
   assign oIdle = !(|nonempty_c) && !wren_q;

`ifdef RESULT_ARB_STATS_EN
   logic [NUM_LANES-1:0] drop_c;
   logic [NUM_LANES-1:0] overflow_q, overflow_d;
   logic [15:0]          drop_cnt_q, drop_cnt_d;
   logic [16:0]          drop_sum_c;

   // A push is lost only when the lane is full and not draining this cycle.
   assign drop_c = iWren & full_c & ~pop_c;

   always_comb begin
      overflow_d = overflow_q | drop_c;
      drop_sum_c = {1'b0, drop_cnt_q};
      for (int i = 0; i < int'(NUM_LANES); i++) begin
         drop_sum_c = drop_sum_c + 17'(drop_c[i]);
      end
      drop_cnt_d = drop_sum_c[16] ? 16'hFFFF : drop_sum_c[15:0];
   end

   always_ff @(posedge clock or negedge not_reset) begin
      if (!not_reset) begin
         overflow_q <= '0;
         drop_cnt_q <= '0;
      end else begin
         overflow_q <= overflow_d;
         drop_cnt_q <= drop_cnt_d;
      end
   end

   assign oOverflow  = overflow_q;
   assign oDropCount = drop_cnt_q;
`endif

endmodule

// File: tb/tb_result_write_arbiter.sv
// Bench for result_write_arbiter: directed vector table, corner-case sequences and a queue-based reference model.
module tb_result_write_arbiter;

   localparam int NL    = 4;
   localparam int DEPTH = 4;

   logic        clock = 1'b0;
   logic        not_reset = 1'b0;
   logic [31:0] iCol = '0, iRow = '0;
   logic [3:0]  iData = '0, iWren = '0;
   logic [3:0]  oFull;
   logic [7:0]  oX, oY;
   logic [2:0]  oR, oG, oB;
   logic        oWren, oIdle;
`ifdef RESULT_ARB_STATS_EN
   logic [3:0]  oOverflow;
   logic [15:0] oDropCount;
`endif

   always #5 clock = ~clock;

   result_write_arbiter dut (
      .not_reset  (not_reset),
      .clock      (clock),
      .iCol       (iCol),
      .iRow       (iRow),
      .iData      (iData),
      .iWren      (iWren),
      .oFull      (oFull),
      .oX         (oX),
      .oY         (oY),
      .oR         (oR),
      .oG         (oG),
      .oB         (oB),
      .oWren      (oWren),
      .oIdle      (oIdle)
`ifdef RESULT_ARB_STATS_EN
      ,
      .oOverflow  (oOverflow),
      .oDropCount (oDropCount)
`endif
   );

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: one queue per lane, grant chosen before this cycle's pushes.
   typedef struct {int row; int col; int pix;} ent_t;
   ent_t       mq [NL][$];
   int         m_last;
   bit         m_wren;
   int         m_x, m_y, m_pix;
   logic [3:0] m_ovf;
   int         m_drops;
   int         m_acc;
   int         full_pop_push;
   int         emitted;

   function automatic int model_grant();
      for (int k = 1; k <= NL; k++) begin
         int l = (m_last + k) % NL;
         if (mq[l].size() > 0) return l;
      end
      return -1;
   endfunction

   task automatic model_reset();
      for (int l = 0; l < NL; l++) mq[l].delete();
      m_last = NL - 1; m_wren = 0; m_x = 0; m_y = 0; m_pix = 0;
      m_ovf = '0; m_drops = 0; m_acc = 0;
   endtask

   task automatic model_step(input logic [3:0] w, input logic [31:0] rb, input logic [31:0] cb, input logic [3:0] d);
      int   g;
      ent_t e;
      g = model_grant();
      m_wren = 0;
      if (g >= 0) begin
         if (g == 1 && mq[1].size() == DEPTH && w[1]) full_pop_push++;
         e = mq[g].pop_front();
         m_wren = 1; m_x = e.row; m_y = e.col; m_pix = e.pix; m_last = g;
      end
      for (int l = 0; l < NL; l++) begin
         if (w[l]) begin
            if (mq[l].size() < DEPTH) begin
               e.row = int'((rb >> (8 * l)) & 32'hFF);
               e.col = int'((cb >> (8 * l)) & 32'hFF);
               e.pix = int'(d[l]);
               mq[l].push_back(e);
               m_acc++;
            end else begin
               m_ovf[l] = 1'b1;
               if (m_drops < 65535) m_drops++;
            end
         end
      end
   endtask

   task automatic compare_model();
      logic [3:0] ef;
      bit         all_empty;
      ef = '0; all_empty = 1;
      for (int l = 0; l < NL; l++) begin
         if (mq[l].size() == DEPTH) ef[l] = 1'b1;
         if (mq[l].size() != 0) all_empty = 0;
      end
      check("wren", 32'(oWren), 32'(m_wren));
      check("row_x", 32'(oX), 32'(m_x));
      check("col_y", 32'(oY), 32'(m_y));
      check("rgb", 32'({oR, oG, oB}), (m_pix != 0) ? 32'h1FF : 32'h0);
      check("full", 32'(oFull), 32'(ef));
      check("idle", 32'(oIdle), 32'(all_empty && !m_wren));
`ifdef RESULT_ARB_STATS_EN
      check("overflow", 32'(oOverflow), 32'(m_ovf));
      check("drop_count", 32'(oDropCount), 32'(m_drops));
`endif
   endtask

   // Called at posedge+1; drives inputs, steps the model at the edge, samples at the next posedge+1.
   task automatic cycle(input logic [3:0] w, input logic [31:0] rb, input logic [31:0] cb,
                        input logic [3:0] d, input bit cmp);
      iWren = w; iRow = rb; iCol = cb; iData = d;
      @(posedge clock);
      model_step(w, rb, cb, d);
      #1;
      if (oWren) emitted++;
      if (cmp) compare_model();
   endtask

   task automatic reset_dut();
      not_reset = 1'b0;
      iWren = '0;
      @(posedge clock);
      #1;
      check("rst_wren", 32'(oWren), 32'h0);
      check("rst_xy", 32'({oX, oY}), 32'h0);
      check("rst_rgb", 32'({oR, oG, oB}), 32'h0);
      check("rst_idle", 32'(oIdle), 32'h1);
      check("rst_full", 32'(oFull), 32'h0);
`ifdef RESULT_ARB_STATS_EN
      check("rst_overflow", 32'(oOverflow), 32'h0);
      check("rst_drop_count", 32'(oDropCount), 32'h0);
`endif
      not_reset = 1'b1;
      model_reset();
   endtask

   typedef struct {
      bit         rst;
      logic [3:0] w;
      logic [31:0] rb, cb;
      logic [3:0] d;
      logic       ewren;
      logic [7:0] ex, ey;
      logic [8:0] ergb;
      logic       eidle;
   } vec_t;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t       vt [9];
      logic [3:0] w, saw_full;
      int         exp_lane, lane, budget;

      // Single write from lane 2, then a four-lane burst straight after reset.
      vt[0] = '{0, 4'b0100, 32'h0005_0000, 32'h0009_0000, 4'b0100, 0, 8'd0,  8'd0,  9'h000, 0};
      vt[1] = '{0, 4'b0000, 32'h0,         32'h0,         4'b0000, 1, 8'd5,  8'd9,  9'h1FF, 0};
      vt[2] = '{0, 4'b0000, 32'h0,         32'h0,         4'b0000, 0, 8'd5,  8'd9,  9'h1FF, 1};
      vt[3] = '{1, 4'b1111, 32'h0D0C_0B0A, 32'h1716_1514, 4'b1010, 0, 8'd0,  8'd0,  9'h000, 0};
      vt[4] = '{0, 4'b0000, 32'h0,         32'h0,         4'b0000, 1, 8'd10, 8'd20, 9'h000, 0};
      vt[5] = '{0, 4'b0000, 32'h0,         32'h0,         4'b0000, 1, 8'd11, 8'd21, 9'h1FF, 0};
      vt[6] = '{0, 4'b0000, 32'h0,         32'h0,         4'b0000, 1, 8'd12, 8'd22, 9'h000, 0};
      vt[7] = '{0, 4'b0000, 32'h0,         32'h0,         4'b0000, 1, 8'd13, 8'd23, 9'h1FF, 0};
      vt[8] = '{0, 4'b0000, 32'h0,         32'h0,         4'b0000, 0, 8'd13, 8'd23, 9'h1FF, 1};

      full_pop_push = 0;
      emitted = 0;
      reset_dut();
      for (int i = 0; i < 9; i++) begin
         if (vt[i].rst) reset_dut();
         cycle(vt[i].w, vt[i].rb, vt[i].cb, vt[i].d, 0);
         check($sformatf("vec%0d_wren", i), 32'(oWren), 32'(vt[i].ewren));
         check($sformatf("vec%0d_xy", i), 32'({oX, oY}), 32'({vt[i].ex, vt[i].ey}));
         check($sformatf("vec%0d_rgb", i), 32'({oR, oG, oB}), 32'(vt[i].ergb));
         check($sformatf("vec%0d_idle", i), 32'(oIdle), 32'(vt[i].eidle));
         check($sformatf("vec%0d_full", i), 32'(oFull), 32'h0);
      end

      // Fairness: lanes 0 and 3 stream together; grants must alternate 0,3,0,3.
      reset_dut();
      exp_lane = 0;
      for (int c = 0; c < 20 + 40; c++) begin
         if (c < 20) cycle(4'b1001, {8'(128 + c), 16'h0, 8'(c)}, $urandom(), 4'($urandom()), 1);
         else        cycle(4'b0000, 32'h0, 32'h0, 4'h0, 1);
         if (oWren) begin
            lane = oX[7] ? 3 : 0;
            check("fair_lane", 32'(lane), 32'(exp_lane));
            exp_lane = (exp_lane == 0) ? 3 : 0;
         end
         if (c >= 20 && oIdle) break;
      end
      check("fair_drained", 32'(oIdle), 32'h1);

      // Overflow: every lane writes every cycle for 12 cycles, ignoring oFull.
      reset_dut();
      emitted = 0;
      saw_full = '0;
      for (int c = 0; c < 12; c++) begin
         cycle(4'hF, $urandom(), $urandom(), 4'($urandom()), 1);
         saw_full |= oFull;
      end
      budget = 0;
      while (!oIdle && budget < 40) begin
         cycle(4'h0, 32'h0, 32'h0, 4'h0, 1);
         budget++;
      end
      check("ovf_drained", 32'(oIdle), 32'h1);
      check("ovf_saw_full", 32'(saw_full), 32'hF);
      check("ovf_emitted_eq_accepted", 32'(emitted), 32'(m_acc));
`ifdef RESULT_ARB_STATS_EN
      check("ovf_sticky", 32'(oOverflow), 32'hF);
      check("ovf_drop_count", 32'(oDropCount), 32'(48 - m_acc));
`endif

      // Full lane 1 pushing on the same cycle it is granted: the push must be kept.
      reset_dut();
      full_pop_push = 0;
      for (int c = 0; c < 16; c++) begin
         w = '0;
         w[1] = (mq[1].size() < DEPTH) || (model_grant() == 1);
         w[0] = (mq[0].size() < DEPTH);
         cycle(w, $urandom(), $urandom(), 4'($urandom()), 1);
      end
      check("full_pop_push_seen", 32'(full_pop_push > 0), 32'h1);
      check("full_pop_lane1_full", 32'(oFull[1]), 32'h1);
`ifdef RESULT_ARB_STATS_EN
      check("full_pop_no_overflow", 32'(oOverflow), 32'h0);
      check("full_pop_no_drops", 32'(oDropCount), 32'h0);
`endif

      // Reset mid-burst with three entries still queued.
      reset_dut();
      cycle(4'hF, $urandom(), $urandom(), 4'hF, 1);
      cycle(4'h0, 32'h0, 32'h0, 4'h0, 1);
      check("mid_pre_wren", 32'(oWren), 32'h1);
      #2 not_reset = 1'b0;
      #1;
      check("mid_rst_wren", 32'(oWren), 32'h0);
      check("mid_rst_idle", 32'(oIdle), 32'h1);
      check("mid_rst_full", 32'(oFull), 32'h0);
      @(posedge clock);
      #1 not_reset = 1'b1;
      model_reset();
      for (int c = 0; c < 6; c++) cycle(4'h0, 32'h0, 32'h0, 4'h0, 1);

      // Randomised traffic, sometimes honouring oFull and sometimes not.
      reset_dut();
      for (int c = 0; c < 400; c++) begin
         w = 4'($urandom()) & 4'($urandom());
         if (c % 100 < 50) w = w & ~oFull;
         cycle(w, $urandom(), $urandom(), 4'($urandom()), 1);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
